fp_operand_streamer: RTL and testbench

- AXI-Stream master that feeds operand pairs to the pipelined floating-point adder/multiplier IP on their s_axis_a / s_axis_b slave ports.
- Upstream control logic writes {a, b, last} words into an internal FIFO.
- The block presents each pair on both channels and tracks per-channel acceptance, so A and B beats are never duplicated or dropped.
- It sits between the convolution-layer operand fetch logic and the floating_adder / floating_mult IP instances.

---
 rtl/fp_stream_pkg.sv | 35 +++
 rtl/fp_stream_fifo.sv | 59 +++++
 rtl/fp_operand_streamer.sv | 143 ++++++++++++++
 tb/tb_fp_operand_streamer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_stream_pkg.sv
// Shared constants, operand-pair word layout and output-stage state encoding
// for the floating-point operand streamer.
package fp_stream_pkg;

  // Default operand width (IEEE-754 single precision).
  localparam int FP_W = 32;

  // Packed FIFO word layout: {last, b, a}. Offsets are functions of the
  // operand width so that an overridden FP_W keeps a consistent layout.
  localparam int A_LSB = 0;

  function automatic int b_lsb(input int fp_w);
    return fp_w;
  endfunction

  function automatic int last_bit(input int fp_w);
    return 2 * fp_w;
  endfunction

  function automatic int word_w(input int fp_w);
    return 2 * fp_w + 1;
  endfunction

  localparam int B_LSB    = b_lsb(FP_W);
  localparam int LAST_BIT = last_bit(FP_W);

  // Output-stage state: which channels of the current beat are still pending.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,  // no beat held
    SEND_BOTH = 2'd1,  // beat held, neither channel accepted yet
    WAIT_A    = 2'd2,  // B accepted, A pending
    WAIT_B    = 2'd3   // A accepted, B pending
  } stream_state_e;

endpackage

// File: rtl/fp_stream_fifo.sv
// Single-clock synchronous FIFO holding packed operand pairs. Pushes while
// full and pops while empty are ignored; the head word is read combinationally.
module fp_stream_fifo #(
  parameter int WORD_W = 65,
  parameter int DEPTH  = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_push,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic              i_pop,
  output logic [WORD_W-1:0] o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);

  logic [WORD_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              w_push;
  logic              w_pop;

  assign o_full  = (r_level == (ADDR_W+1)'(DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];

  // A push while full is dropped even if a pop happens in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  // Storage array write.
  // NOTE: the data array has no reset; the pointers and level define which
  // entries are valid, so resetting storage would only cost flops and fanout.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

  // Pointer and occupancy tracking; pointers wrap naturally modulo DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_level <= r_level + 1'b1;
        2'b01:   r_level <= r_level - 1'b1;
        default: r_level <= r_level;
      endcase
    end
  end

endmodule

// File: rtl/fp_operand_streamer.sv
// AXI-Stream master presenting queued operand pairs on two channels (A and B)
// to the floating-point IP, tracking per-channel acceptance so neither beat
// is duplicated or dropped.
module fp_operand_streamer
  import fp_stream_pkg::*;
#(
  parameter int FP_W  = fp_stream_pkg::FP_W,
  parameter int DEPTH = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            wr_en,
  input  logic [FP_W-1:0] wr_a,
  input  logic [FP_W-1:0] wr_b,
  input  logic            wr_last,
  output logic            full,
  output logic            empty,
  output logic [ADDR_W:0] level,
  output logic            overflow,
  input  logic            ovf_clr,
  output logic            m_axis_a_tvalid,
  output logic [FP_W-1:0] m_axis_a_tdata,
  output logic            m_axis_a_tlast,
  input  logic            m_axis_a_tready,
  output logic            m_axis_b_tvalid,
  output logic [FP_W-1:0] m_axis_b_tdata,
  input  logic            m_axis_b_tready,
  output logic [15:0]     frame_cnt,
  output logic            busy
);

  localparam int L_WORD_W   = word_w(FP_W);
  localparam int L_B_LSB    = b_lsb(FP_W);
  localparam int L_LAST_BIT = last_bit(FP_W);

  stream_state_e       r_state;
  stream_state_e       w_state_next;
  logic [FP_W-1:0]     r_out_a;
  logic [FP_W-1:0]     r_out_b;
  logic                r_out_last;
  logic [15:0]         r_frame_cnt;
  logic                r_overflow;
  logic [L_WORD_W-1:0] w_fifo_wdata;
  logic [L_WORD_W-1:0] w_fifo_rdata;
  logic                w_out_vld;
  logic                w_a_hs;
  logic                w_b_hs;
  logic                w_complete;
  logic                w_load;

  assign w_fifo_wdata = {wr_last, wr_b, wr_a};

  fp_stream_fifo #(
    .WORD_W (L_WORD_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (wr_en),
    .i_wdata (w_fifo_wdata),
    .i_pop   (w_load),
    .o_rdata (w_fifo_rdata),
    .o_full  (full),
    .o_empty (empty),
    .o_level (level)
  );

  // Handshakes, beat completion and the pop/load decision.
  assign w_a_hs     = m_axis_a_tvalid & m_axis_a_tready;
  assign w_b_hs     = m_axis_b_tvalid & m_axis_b_tready;
  assign w_complete = w_out_vld & (~m_axis_a_tvalid | w_a_hs) & (~m_axis_b_tvalid | w_b_hs);
  assign w_load     = ~empty & (~w_out_vld | w_complete);

  // State register.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of the order the simulator runs the blocks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_next;
  end

  // Next-state logic: record per-channel acceptance until the beat completes.
  // NOTE: the default assignment at the top keeps this block free of latches.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_load) w_state_next = SEND_BOTH;
      end
      SEND_BOTH: begin
        if (w_complete)  w_state_next = w_load ? SEND_BOTH : IDLE;
        else if (w_a_hs) w_state_next = WAIT_B;
        else if (w_b_hs) w_state_next = WAIT_A;
      end
      WAIT_A, WAIT_B: begin
        if (w_complete) w_state_next = w_load ? SEND_BOTH : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Output decode: valids come from registered state only, never from tready.
  always_comb begin
    w_out_vld       = (r_state != IDLE);
    m_axis_a_tvalid = (r_state == SEND_BOTH) || (r_state == WAIT_A);
    m_axis_b_tvalid = (r_state == SEND_BOTH) || (r_state == WAIT_B);
  end

  // Output data register: only changes when a new pair is popped, so data is
  // stable for as long as either channel still shows valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_a    <= '0;
      r_out_b    <= '0;
      r_out_last <= 1'b0;
    end else if (w_load) begin
      r_out_a    <= w_fifo_rdata[A_LSB +: FP_W];
      r_out_b    <= w_fifo_rdata[L_B_LSB +: FP_W];
      r_out_last <= w_fifo_rdata[L_LAST_BIT];
    end
  end

  // Frame counter (wraps) and sticky overflow flag where set beats clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_frame_cnt <= '0;
      r_overflow  <= 1'b0;
    end else begin
      if (w_complete && r_out_last) r_frame_cnt <= r_frame_cnt + 16'd1;
      if (wr_en && full)            r_overflow  <= 1'b1;
      else if (ovf_clr)             r_overflow  <= 1'b0;
    end
  end

  assign m_axis_a_tdata = r_out_a;
  assign m_axis_a_tlast = r_out_last;
  assign m_axis_b_tdata = r_out_b;
  assign frame_cnt      = r_frame_cnt;
  assign overflow       = r_overflow;
  assign busy           = ~empty | w_out_vld;

endmodule

// File: tb/tb_fp_operand_streamer.sv
// Self-checking bench for fp_operand_streamer: directed scenarios plus a
// randomized stall run, with a queue-based scoreboard of accepted pairs.
module tb_fp_operand_streamer;

  localparam int W     = 32;
  localparam int DEPTH = 16;
  localparam int AW    = $clog2(DEPTH);

  logic          clk;
  logic          rst_n;
  logic          wr_en;
  logic [W-1:0]  wr_a;
  logic [W-1:0]  wr_b;
  logic          wr_last;
  logic          full;
  logic          empty;
  logic [AW:0]   level;
  logic          overflow;
  logic          ovf_clr;
  logic          m_axis_a_tvalid;
  logic [W-1:0]  m_axis_a_tdata;
  logic          m_axis_a_tlast;
  logic          m_axis_a_tready;
  logic          m_axis_b_tvalid;
  logic [W-1:0]  m_axis_b_tdata;
  logic          m_axis_b_tready;
  logic [15:0]   frame_cnt;
  logic          busy;

  fp_operand_streamer #(.FP_W(W), .DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .wr_en           (wr_en),
    .wr_a            (wr_a),
    .wr_b            (wr_b),
    .wr_last         (wr_last),
    .full            (full),
    .empty           (empty),
    .level           (level),
    .overflow        (overflow),
    .ovf_clr         (ovf_clr),
    .m_axis_a_tvalid (m_axis_a_tvalid),
    .m_axis_a_tdata  (m_axis_a_tdata),
    .m_axis_a_tlast  (m_axis_a_tlast),
    .m_axis_a_tready (m_axis_a_tready),
    .m_axis_b_tvalid (m_axis_b_tvalid),
    .m_axis_b_tdata  (m_axis_b_tdata),
    .m_axis_b_tready (m_axis_b_tready),
    .frame_cnt       (frame_cnt),
    .busy            (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  // Reference model: every accepted pair is expected exactly once on each
  // channel, in write order; frames count accepted pairs carrying last.
  logic [W-1:0] qa[$];
  logic         ql[$];
  logic [W-1:0] qb[$];
  int           exp_frames = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One write cycle; acc says whether the model expects the pair to be taken.
  task automatic push(input logic [W-1:0] a, input logic [W-1:0] b, input logic l, input bit acc);
    wr_en = 1'b1; wr_a = a; wr_b = b; wr_last = l;
    if (acc) begin
      qa.push_back(a); ql.push_back(l); qb.push_back(b);
      if (l) exp_frames++;
    end
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 200) begin
      tick();
      c++;
    end
    check({tag, "_drain"}, 64'(busy), 64'd0);
  endtask

  // Bus monitor, sampled mid-cycle: scoreboard every handshake and require
  // data to hold while a channel is stalled.
  logic         prev_a_stall, prev_b_stall;
  logic [W:0]   prev_a;
  logic [W-1:0] prev_b;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_a_stall = 1'b0;
      prev_b_stall = 1'b0;
    end else begin
      if (prev_a_stall && m_axis_a_tvalid)
        check("a_hold", 64'({m_axis_a_tlast, m_axis_a_tdata}), 64'(prev_a));
      if (prev_b_stall && m_axis_b_tvalid)
        check("b_hold", 64'(m_axis_b_tdata), 64'(prev_b));
      if (m_axis_a_tvalid && m_axis_a_tready) begin
        check("a_beat_expected", 64'(qa.size() > 0), 64'd1);
        if (qa.size() > 0) begin
          check("a_data", 64'({m_axis_a_tlast, m_axis_a_tdata}), 64'({ql[0], qa[0]}));
          void'(qa.pop_front());
          void'(ql.pop_front());
        end
      end
      if (m_axis_b_tvalid && m_axis_b_tready) begin
        check("b_beat_expected", 64'(qb.size() > 0), 64'd1);
        if (qb.size() > 0) begin
          check("b_data", 64'(m_axis_b_tdata), 64'(qb[0]));
          void'(qb.pop_front());
        end
      end
      prev_a_stall = m_axis_a_tvalid & ~m_axis_a_tready;
      prev_b_stall = m_axis_b_tvalid & ~m_axis_b_tready;
      prev_a       = {m_axis_a_tlast, m_axis_a_tdata};
      prev_b       = m_axis_b_tdata;
    end
  end

  initial begin
    int na, nb, cyc, sent, seen;
    logic [W-1:0] ra, rb;
    logic         rl;

    rst_n = 1'b0; wr_en = 1'b0; wr_a = '0; wr_b = '0; wr_last = 1'b0;
    ovf_clr = 1'b0; m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;

    // ---- Reset state ----
    #12;
    check("rst_a_tvalid", 64'(m_axis_a_tvalid), 64'd0);
    check("rst_b_tvalid", 64'(m_axis_b_tvalid), 64'd0);
    check("rst_empty",    64'(empty),           64'd1);
    check("rst_full",     64'(full),            64'd0);
    check("rst_level",    64'(level),           64'd0);
    check("rst_busy",     64'(busy),            64'd0);
    check("rst_frame",    64'(frame_cnt),       64'd0);
    check("rst_ovf",      64'(overflow),        64'd0);
    @(negedge clk); rst_n = 1'b1;
    tick();

    // ---- Single pair: valid appears two cycles after the write ----
    push(32'h42C80000, 32'h40200000, 1'b1, 1'b1);
    check("single_n1_vld", 64'({m_axis_a_tvalid, m_axis_b_tvalid}), 64'd0);
    check("single_n1_busy", 64'(busy), 64'd1);
    tick();
    check("single_n2_vld",  64'({m_axis_a_tvalid, m_axis_b_tvalid}), 64'd3);
    check("single_n2_a",    64'(m_axis_a_tdata), 64'h42C80000);
    check("single_n2_b",    64'(m_axis_b_tdata), 64'h40200000);
    check("single_n2_last", 64'(m_axis_a_tlast), 64'd1);
    tick();
    check("single_n3_busy",  64'(busy), 64'd0);
    check("single_n3_frame", 64'(frame_cnt), 64'(exp_frames));

    // ---- Skewed ready: A accepted at once, B stalled three cycles ----
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b0;
    push(32'h3F800000, 32'h40000000, 1'b0, 1'b1);
    push(32'h40400000, 32'h40800000, 1'b0, 1'b1);
    na = 0; nb = 0;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) m_axis_b_tready = 1'b1;
      na += int'(m_axis_a_tvalid);
      nb += int'(m_axis_b_tvalid);
      tick();
    end
    check("skew_a_cycles", 64'(na), 64'd1);
    check("skew_b_cycles", 64'(nb), 64'd4);
    check("skew_next_vld", 64'({m_axis_a_tvalid, m_axis_b_tvalid}), 64'd3);
    check("skew_next_a",   64'(m_axis_a_tdata), 64'h40400000);
    wait_idle("skew");

    // ---- Streaming: 8 pairs back-to-back, no bubbles after the first ----
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        wr_en   = 1'b1;
        wr_a    = (k % 2 == 0) ? 32'h44034000 : 32'h42C80000;
        wr_b    = (k % 2 == 0) ? 32'h41B28007 : 32'h40200000;
        wr_last = (k == 3) || (k == 7);
        qa.push_back(wr_a); ql.push_back(wr_last); qb.push_back(wr_b);
        if (wr_last) exp_frames++;
      end else begin
        wr_en = 1'b0;
      end
      check($sformatf("stream_vld%0d", k), 64'({m_axis_a_tvalid, m_axis_b_tvalid}),
            (k >= 2 && k <= 9) ? 64'd3 : 64'd0);
      tick();
    end
    wr_en = 1'b0;
    wait_idle("stream");
    check("stream_frame", 64'(frame_cnt), 64'(exp_frames[15:0]));

    // ---- Full / overflow: first pair parks in the output register, ----
    // ---- sixteen fill the FIFO, the eighteenth is dropped.         ----
    m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b0;
    for (int i = 0; i < 18; i++) begin
      push(32'h10000000 + W'(i), 32'h20000000 + W'(i), 1'b0, i < 17);
      if (i == 16) begin
        check("fill_level", 64'(level),    64'd16);
        check("fill_full",  64'(full),     64'd1);
        check("fill_ovf",   64'(overflow), 64'd0);
      end
    end
    check("ovf_set", 64'(overflow), 64'd1);
    check("ovf_level_held", 64'(level), 64'd16);
    // Write while full plus a pop plus a clear: write dropped, set wins.
    wr_en = 1'b1; wr_a = 32'hDEADBEEF; wr_b = 32'hDEADBEEF; ovf_clr = 1'b1;
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    tick();
    wr_en = 1'b0; m_axis_a_tready = 1'b0; m_axis_b_tready = 1'b0;
    check("ovf_set_wins",    64'(overflow), 64'd1);
    check("ovf_pop_level",   64'(level),    64'd15);
    tick();
    ovf_clr = 1'b0;
    check("ovf_cleared", 64'(overflow), 64'd0);
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    wait_idle("ovf");
    check("ovf_sb_a_empty", 64'(qa.size()), 64'd0);
    check("ovf_sb_b_empty", 64'(qb.size()), 64'd0);

    // ---- Wrap-around: 40 random pairs with random stalls ----
    cyc = 0; sent = 0;
    while ((sent < 40 || busy) && cyc < 3000) begin
      m_axis_a_tready = ($urandom_range(0, 3) != 0);
      m_axis_b_tready = ($urandom_range(0, 3) != 0);
      if (sent < 40 && !full && $urandom_range(0, 3) != 0) begin
        ra = $urandom; rb = $urandom; rl = $urandom_range(0, 1) == 1;
        wr_en = 1'b1; wr_a = ra; wr_b = rb; wr_last = rl;
        qa.push_back(ra); ql.push_back(rl); qb.push_back(rb);
        if (rl) exp_frames++;
        sent++;
      end else begin
        wr_en = 1'b0;
      end
      tick();
      cyc++;
    end
    wr_en = 1'b0; m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b1;
    check("wrap_budget",     64'(cyc < 3000), 64'd1);
    check("wrap_sb_a_empty", 64'(qa.size()), 64'd0);
    check("wrap_sb_b_empty", 64'(qb.size()), 64'd0);
    check("wrap_level",      64'(level), 64'd0);
    check("wrap_empty",      64'(empty), 64'd1);
    check("wrap_frame",      64'(frame_cnt), 64'(exp_frames[15:0]));

    // ---- Reset mid-beat in WAIT_B with five pairs queued ----
    m_axis_a_tready = 1'b1; m_axis_b_tready = 1'b0;
    for (int i = 0; i < 6; i++) push(32'h30000000 + W'(i), 32'h31000000 + W'(i), 1'b1, 1'b1);
    check("rb_wait_b", 64'({m_axis_a_tvalid, m_axis_b_tvalid}), 64'd1);
    check("rb_level",  64'(level), 64'd5);
    #2 rst_n = 1'b0;
    #1;
    check("rb_vld_now",  64'({m_axis_a_tvalid, m_axis_b_tvalid}), 64'd0);
    check("rb_busy_now", 64'(busy), 64'd0);
    qa.delete(); ql.delete(); qb.delete();
    exp_frames = 0;
    @(negedge clk); #1 rst_n = 1'b1;
    m_axis_b_tready = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += int'(m_axis_a_tvalid | m_axis_b_tvalid);
    end
    check("rb_no_residual", 64'(seen), 64'd0);
    check("rb_empty",       64'(empty), 64'd1);
    check("rb_level0",      64'(level), 64'd0);
    check("rb_frame",       64'(frame_cnt), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
